// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file widths and write-arbiter FSM states
package cpu_pkg;
    localparam int REG_AW = 5;
    localparam int DW = 32;
    typedef enum logic {ARB_IDLE, ARB_FORCE} arb_state_e;
endpackage

// File: rtl/rf_wbuf.sv
// rf_wbuf: circular buffer of pending MDU register writes with per-entry live bits
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   push_*_i               enqueue {addr, data} at the tail (entry starts live)
//   pop_i                  retire the head entry
//   kill_i, kill_addr_i    clear live on every entry whose addr matches
//   rs_i, rt_i             decode read addresses compared against live entries
//   head_*_o               head entry contents
//   count_o                occupied slots
//   match_o                per-slot live destination match against rs_i/rt_i
module rf_wbuf import cpu_pkg::*; #(
    parameter int DEPTH = 2,
    parameter int DW = cpu_pkg::DW
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      push_i,
    input  logic [REG_AW-1:0]         push_addr_i,
    input  logic [DW-1:0]             push_data_i,
    input  logic                      pop_i,
    input  logic                      kill_i,
    input  logic [REG_AW-1:0]         kill_addr_i,
    input  logic [REG_AW-1:0]         rs_i,
    input  logic [REG_AW-1:0]         rt_i,
    output logic                      head_live_o,
    output logic [REG_AW-1:0]         head_addr_o,
    output logic [DW-1:0]             head_data_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic [DEPTH-1:0]          match_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0]  live_q, live_d;
    logic [REG_AW-1:0] addr_q [DEPTH];
    logic [DW-1:0]     data_q [DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [AW:0]       count_q;

    // Kill first, then retire the head, then mark the new tail live, so a
    // same-cycle kill never reaches the entry being pushed. Push and pop can
    // only coincide when 0 < count < DEPTH, so the two slots always differ.
    always_comb begin
        live_d = live_q;
        for (int i = 0; i < DEPTH; i++)
            if (kill_i && addr_q[i] == kill_addr_i) live_d[i] = 1'b0;
        if (pop_i) live_d[rptr_q] = 1'b0;
        if (push_i) live_d[wptr_q] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            live_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            live_q  <= live_d;
            count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
            if (push_i) begin
                addr_q[wptr_q] <= push_addr_i;
                data_q[wptr_q] <= push_data_i;
                wptr_q         <= wptr_q + AW'(1);
            end
            if (pop_i) rptr_q <= rptr_q + AW'(1);
        end
    end

    // Retired slots have live cleared, so live alone marks real pending writes.
    always_comb begin
        match_o = '0;
        for (int i = 0; i < DEPTH; i++)
            match_o[i] = live_q[i] && addr_q[i] != '0 && (addr_q[i] == rs_i || addr_q[i] == rt_i);
    end

    assign head_live_o = live_q[rptr_q];
    assign head_addr_o = addr_q[rptr_q];
    assign head_data_o = data_q[rptr_q];
    assign count_o     = count_q;
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between WB (priority) and buffered MDU results
//   CLK, RST                        clock, asynchronous active-low reset
//   wb_valid/wb_addr/wb_data        write-back request; wb_stall tells WB to hold it
//   mdu_valid/mdu_addr/mdu_data     MDU result offer; mdu_ready accepts it
//   rs, rt, hazard                  decode read addresses and pending-write hazard flag
//   RegWre, write, writeData        register-file write port
//   buf_count                       occupied MDU buffer slots
module rf_write_arbiter import cpu_pkg::*; #(
    parameter int DEPTH = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int DW = cpu_pkg::DW
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   wb_valid,
    input  logic [REG_AW-1:0]      wb_addr,
    input  logic [DW-1:0]          wb_data,
    output logic                   wb_stall,
    input  logic                   mdu_valid,
    output logic                   mdu_ready,
    input  logic [REG_AW-1:0]      mdu_addr,
    input  logic [DW-1:0]          mdu_data,
    input  logic [REG_AW-1:0]      rs,
    input  logic [REG_AW-1:0]      rt,
    output logic                   hazard,
    output logic                   RegWre,
    output logic [REG_AW-1:0]      write,
    output logic [DW-1:0]          writeData,
    output logic [$clog2(DEPTH):0] buf_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int GW = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
    localparam logic [GW-1:0] AGE_MAX  = GW'(STARVE_LIMIT);
    localparam logic [GW-1:0] AGE_TRIP = GW'(STARVE_LIMIT - 1);

    arb_state_e        state_q, state_d;
    logic [GW-1:0]     age_q, age_d;
    logic              non_empty, wb_req, grant_wb, pop, push;
    logic              head_live;
    logic [REG_AW-1:0] head_addr;
    logic [DW-1:0]     head_data;
    logic [DEPTH-1:0]  match;

    // Gating with RST keeps the write port quiet while reset is held.
    assign non_empty = buf_count != '0;
    assign wb_req    = RST && wb_valid && wb_addr != '0;
    // A same-cycle pop does not open a slot for a push into a full buffer.
    assign mdu_ready = RST && buf_count < FULL;
    assign push      = mdu_valid && mdu_ready && mdu_addr != '0;
    assign hazard    = |match;

    rf_wbuf #(.DEPTH(DEPTH), .DW(DW)) u_wbuf (
        .clk_i       (CLK),
        .rst_ni      (RST),
        .push_i      (push),
        .push_addr_i (mdu_addr),
        .push_data_i (mdu_data),
        .pop_i       (pop),
        .kill_i      (grant_wb),
        .kill_addr_i (wb_addr),
        .rs_i        (rs),
        .rt_i        (rt),
        .head_live_o (head_live),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .count_o     (buf_count),
        .match_o     (match)
    );

    // FORCE drains the head while WB holds its request; in IDLE WB wins and
    // the head only drains on cycles WB leaves free.
    always_comb begin
        state_d  = ARB_IDLE;
        wb_stall = 1'b0;
        grant_wb = 1'b0;
        pop      = 1'b0;
        if (state_q == ARB_FORCE) begin
            wb_stall = 1'b1;
            pop      = non_empty;
        end else begin
            grant_wb = wb_req;
            pop      = non_empty && !wb_req;
            if (non_empty && !pop && age_q == AGE_TRIP) state_d = ARB_FORCE;
        end
        RegWre    = grant_wb || (pop && head_live);
        write     = grant_wb ? wb_addr : pop ? head_addr : '0;
        writeData = grant_wb ? wb_data : pop ? head_data : '0;
    end

    assign age_d = (!non_empty || pop) ? '0 : (age_q == AGE_MAX) ? age_q : age_q + GW'(1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ARB_IDLE;
            age_q   <= '0;
        end else begin
            state_q <= state_d;
            age_q   <= age_d;
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: vector table, corner sequences and randomized queue-model check of rf_write_arbiter
module tb_rf_write_arbiter;
    localparam int DEPTH = 2;
    localparam int STARVE = 4;
    localparam int DW = 32;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        wb_valid, mdu_valid;
    logic [4:0]  wb_addr, mdu_addr, rs, rt;
    logic [31:0] wb_data, mdu_data;
    logic        wb_stall, mdu_ready, hazard, RegWre;
    logic [4:0]  write;
    logic [31:0] writeData;
    logic [1:0]  buf_count;

    rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE), .DW(DW)) dut (
        .CLK(CLK), .RST(RST),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_stall(wb_stall),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
        .rs(rs), .rt(rt), .hazard(hazard),
        .RegWre(RegWre), .write(write), .writeData(writeData), .buf_count(buf_count)
    );

    always #5 CLK = ~CLK;

    int nvec = 0;
    int nbad = 0;
    string tag = "";
    logic [31:0] rf [32];

    typedef struct {
        logic [31:0] wv, wa, wd, mv, ma, md, rs, rt;
        logic [31:0] we, xa, xd, st, rdy, hz, cnt;
    } vec_t;
    vec_t tbl[$];

    typedef struct {
        bit          live;
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;
    ent_t mq[$];
    int   mage = 0;
    bit   mfrc = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s %s: got %h expected %h", tag, name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [31:0] wv, wa, wd, mv, ma, md, r1, r2,
                                logic [31:0] we, xa, xd, st, rdy, hz, cnt);
        vec_t v;
        v.wv = wv; v.wa = wa; v.wd = wd; v.mv = mv; v.ma = ma; v.md = md; v.rs = r1; v.rt = r2;
        v.we = we; v.xa = xa; v.xd = xd; v.st = st; v.rdy = rdy; v.hz = hz; v.cnt = cnt;
        return v;
    endfunction

    // Reference model: a queue of pending writes, an age count and a force flag.
    task automatic model_step();
        bit wbreq, grant, ne, pop, push, nfrc;
        wbreq = wb_valid && wb_addr != 0;
        grant = !mfrc && wbreq;
        ne    = mq.size() != 0;
        pop   = ne && (mfrc || !wbreq);
        push  = mdu_valid && mq.size() < DEPTH && mdu_addr != 0;
        nfrc  = !mfrc && ne && !pop && mage == STARVE - 1;
        if (grant) foreach (mq[i]) if (mq[i].addr == wb_addr) mq[i].live = 1'b0;
        if (pop) mq.delete(0);
        if (push) mq.push_back('{1'b1, mdu_addr, mdu_data});
        mage = (!ne || pop) ? 0 : (mage < STARVE ? mage + 1 : mage);
        mfrc = nfrc;
    endtask

    task automatic apply(vec_t v);
        wb_valid = v.wv[0]; wb_addr = v.wa[4:0]; wb_data = v.wd;
        mdu_valid = v.mv[0]; mdu_addr = v.ma[4:0]; mdu_data = v.md;
        rs = v.rs[4:0]; rt = v.rt[4:0];
        #2;
        chk("RegWre", 32'(RegWre), v.we);
        chk("write", 32'(write), v.xa);
        chk("writeData", writeData, v.xd);
        chk("wb_stall", 32'(wb_stall), v.st);
        chk("mdu_ready", 32'(mdu_ready), v.rdy);
        chk("hazard", 32'(hazard), v.hz);
        chk("buf_count", 32'(buf_count), v.cnt);
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic rnd_cycle();
        bit wbreq, grant, ne, pop, ewe, hz;
        logic [4:0] ewa;
        logic [31:0] ewd;
        if (!mfrc) begin
            wb_valid = ($urandom_range(0, 9) < 6);
            wb_addr  = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
        end
        mdu_valid = 1'($urandom_range(0, 1));
        mdu_addr  = 5'($urandom_range(0, 7));
        mdu_data  = $urandom;
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        wbreq = wb_valid && wb_addr != 0;
        grant = !mfrc && wbreq;
        ne    = mq.size() != 0;
        pop   = ne && (mfrc || !wbreq);
        ewe   = grant || (pop && mq[0].live);
        ewa   = grant ? wb_addr : pop ? mq[0].addr : 5'd0;
        ewd   = grant ? wb_data : pop ? mq[0].data : 32'd0;
        hz    = 1'b0;
        foreach (mq[i]) if (mq[i].live && mq[i].addr != 0 && (mq[i].addr == rs || mq[i].addr == rt)) hz = 1'b1;
        #2;
        chk("RegWre", 32'(RegWre), 32'(ewe));
        chk("write", 32'(write), 32'(ewa));
        chk("writeData", writeData, ewd);
        chk("wb_stall", 32'(wb_stall), 32'(mfrc));
        chk("mdu_ready", 32'(mdu_ready), 32'(mq.size() < DEPTH));
        chk("hazard", 32'(hazard), 32'(hz));
        chk("buf_count", 32'(buf_count), 32'(mq.size()));
        @(posedge CLK);
        model_step();
        #1;
    endtask

    // Register file shadow written on the falling edge, plus the occupancy bound.
    always @(negedge CLK) begin
        if (RegWre === 1'b1) rf[write] = writeData;
        nvec++;
        if (32'(buf_count) > DEPTH) begin
            nbad++;
            $display("FAIL bound buf_count: got %0d limit %0d", buf_count, DEPTH);
        end
    end

    initial begin
        foreach (rf[i]) rf[i] = '0;
        wb_valid = 0; wb_addr = 0; wb_data = 0;
        mdu_valid = 0; mdu_addr = 0; mdu_data = 0; rs = 0; rt = 0;
        #8;
        tag = "reset";
        chk("RegWre", 32'(RegWre), 0);
        chk("write", 32'(write), 0);
        chk("writeData", writeData, 0);
        chk("wb_stall", 32'(wb_stall), 0);
        chk("hazard", 32'(hazard), 0);
        chk("buf_count", 32'(buf_count), 0);
        #8 RST = 1'b1;
        #2 chk("mdu_ready", 32'(mdu_ready), 1);
        @(posedge CLK);
        #1;

        //            wv wa  wd      mv ma  md           rs rt   we xa  xd          st rdy hz cnt
        tbl.push_back(mk(0, 0, 0,      1, 5, 'hA5A5A5A5, 5, 0,   0, 0, 0,          0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,          5, 0,   1, 5, 'hA5A5A5A5, 0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,          5, 0,   0, 0, 0,          0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0,      1, 3, 1,          3, 0,   0, 0, 0,          0, 1, 0, 0));
        tbl.push_back(mk(1, 4, 2,      0, 0, 0,          3, 0,   1, 4, 2,          0, 1, 1, 1));
        tbl.push_back(mk(1, 4, 2,      0, 0, 0,          3, 0,   1, 4, 2,          0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,          3, 0,   1, 3, 1,          0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,          3, 0,   0, 0, 0,          0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0,      1, 7, 'h11,       7, 0,   0, 0, 0,          0, 1, 0, 0));
        tbl.push_back(mk(1, 7, 'h22,   0, 0, 0,          7, 0,   1, 7, 'h22,       0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,          7, 0,   0, 7, 'h11,       0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,          7, 0,   0, 0, 0,          0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 'hAA,   1, 10, 'h10,      0, 10,  1, 1, 'hAA,       0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 'hAB,   1, 11, 'h11,      0, 10,  1, 1, 'hAB,       0, 1, 1, 1));
        tbl.push_back(mk(1, 1, 'hAC,   1, 12, 'h12,      11, 10, 1, 1, 'hAC,       0, 0, 1, 2));
        tbl.push_back(mk(0, 0, 0,      1, 12, 'h12,      0, 10,  1, 10, 'h10,      0, 0, 1, 2));
        tbl.push_back(mk(0, 0, 0,      1, 12, 'h12,      0, 10,  1, 11, 'h11,      0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,          0, 10,  1, 12, 'h12,      0, 1, 0, 1));
        tbl.push_back(mk(1, 0, 'hFF,   1, 13, 'h13,      0, 0,   0, 0, 0,          0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 'hFF,   0, 0, 0,          0, 0,   1, 13, 'h13,      0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0,      1, 0, 'h77,       0, 0,   0, 0, 0,          0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,          0, 0,   0, 0, 0,          0, 1, 0, 0));
        tbl.push_back(mk(1, 2, 'h20,   1, 9, 'h99,       9, 0,   1, 2, 'h20,       0, 1, 0, 0));
        tbl.push_back(mk(1, 2, 'h21,   0, 0, 0,          9, 0,   1, 2, 'h21,       0, 1, 1, 1));
        tbl.push_back(mk(1, 2, 'h22,   0, 0, 0,          9, 0,   1, 2, 'h22,       0, 1, 1, 1));
        tbl.push_back(mk(1, 2, 'h23,   0, 0, 0,          9, 0,   1, 2, 'h23,       0, 1, 1, 1));
        tbl.push_back(mk(1, 2, 'h24,   0, 0, 0,          9, 0,   1, 2, 'h24,       0, 1, 1, 1));
        tbl.push_back(mk(1, 2, 'h25,   0, 0, 0,          9, 0,   1, 9, 'h99,       1, 1, 1, 1));
        tbl.push_back(mk(1, 2, 'h25,   0, 0, 0,          9, 0,   1, 2, 'h25,       0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,          9, 0,   0, 0, 0,          0, 1, 0, 0));
        foreach (tbl[i]) begin
            tag = $sformatf("row%0d", i);
            apply(tbl[i]);
        end

        tag = "regfile";
        chk("r5", rf[5], 'hA5A5A5A5);
        chk("r3", rf[3], 1);
        chk("r7", rf[7], 'h22);
        chk("r9", rf[9], 'h99);
        chk("r2", rf[2], 'h25);
        chk("r13", rf[13], 'h13);
        chk("r0", rf[0], 0);

        tag = "rstmid";
        apply(mk(1, 1, 1, 1, 20, 'h20, 20, 0, 1, 1, 1, 0, 1, 0, 0));
        apply(mk(1, 1, 1, 1, 21, 'h21, 20, 0, 1, 1, 1, 0, 1, 1, 1));
        wb_valid = 0; mdu_valid = 0; rs = 21;
        #1;
        chk("buf_count", 32'(buf_count), 2);
        chk("RegWre", 32'(RegWre), 1);
        chk("write", 32'(write), 20);
        chk("hazard", 32'(hazard), 1);
        #1 RST = 1'b0;
        #1;
        chk("async buf_count", 32'(buf_count), 0);
        chk("async RegWre", 32'(RegWre), 0);
        chk("async hazard", 32'(hazard), 0);
        chk("async wb_stall", 32'(wb_stall), 0);
        chk("async write", 32'(write), 0);
        chk("async writeData", writeData, 0);
        mq.delete();
        mage = 0;
        mfrc = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        tag = "postrst";
        repeat (3) apply(mk(0, 0, 0, 0, 0, 0, 20, 21, 0, 0, 0, 0, 1, 0, 0));
        chk("r20", rf[20], 0);
        chk("r21", rf[21], 0);

        for (int k = 0; k < 3000; k++) begin
            tag = $sformatf("rnd%0d", k);
            rnd_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port between two requesters: the pipeline write-back stage (WB) and the multi-cycle multiply/divide/load-return unit (MDU).
- WB has priority. MDU results queue in a small buffer and drain on idle WB cycles.
- A starvation guard stalls WB so a buffered result is eventually written.
- The block drives the register file's RegWre/write/writeData, and gives decode a hazard flag for buffered destinations.

Parameters:
- DEPTH, 2, MDU buffer entries (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive denied cycles of a valid buffer head before a forced drain
- DW, 32, data width

Ports:
- CLK  in  1  clock; state updates on posedge
- RST  in  1  asynchronous, active-low reset
- wb_valid  in  1  WB write request this cycle
- wb_addr  in  5  WB destination register
- wb_data  in  DW  WB write data
- wb_stall  out  1  registered; WB must hold its request this cycle
- mdu_valid  in  1  MDU result offered
- mdu_ready  out  1  buffer can accept (count < DEPTH)
- mdu_addr  in  5  MDU destination register
- mdu_data  in  DW  MDU result
- rs  in  5  decode read address 1
- rt  in  5  decode read address 2
- hazard  out  1  rs or rt matches a live buffered destination
- RegWre  out  1  register file write enable
- write  out  5  register file write address
- writeData  out  DW  register file write data
- buf_count  out  $clog2(DEPTH)+1  occupied buffer slots

Behaviour:
- Reset (RST low, async):
  - buffer emptied; all entries invalidated, including any held mid-operation
  - buf_count=0, age=0, FSM=IDLE
  - wb_stall=0, RegWre=0, write=0, writeData=0, hazard=0, mdu_ready=1 once RST is high
- Port outputs are combinational from current state and inputs, so they are stable before the register file's negedge write.
- Buffer: circular FIFO of {live, addr, data}.
  - Push on mdu_valid&&mdu_ready.
  - mdu_ready = (buf_count<DEPTH) only; a pop in the same cycle does not free a slot for a full-buffer push.
  - A push with mdu_addr==0 completes the handshake but is not enqueued.
- Grant, FSM IDLE:
  - wb_valid && wb_addr!=0: write WB. RegWre=1, write=wb_addr, writeData=wb_data. No pop.
  - Otherwise, if buffer non-empty: pop head. RegWre=head.live, write=head.addr, writeData=head.data.
  - Otherwise RegWre=0.
  - wb_valid with wb_addr==0 counts as no WB request: no write, and the head may pop.
- Minimum MDU latency: push at cycle N, earliest write at cycle N+1. There is no bypass.
- WAW kill: a WB write is program-order younger than all buffered entries. On a granted WB write, every live entry with addr==wb_addr has live cleared in that cycle. A dead entry still pops in its turn, using the slot with RegWre=0.
- Simultaneous push and pop: count unchanged; the pushed entry goes to the tail. A same-cycle WB kill does not apply to the entry being pushed.
- Starvation guard, age counter:
  - Increments each posedge the buffer is non-empty and the head is not popped.
  - Clears on any pop or when the buffer is empty.
  - Saturates at STARVE_LIMIT.
- FSM states:
  - IDLE → FORCE when age==STARVE_LIMIT-1 and the head is denied this cycle.
  - FORCE (exactly one cycle): wb_stall=1 and the head is popped regardless of wb_valid. WB holds its request, and no WAW kill applies. Then → IDLE.
- wb_stall is 1 only in FORCE.
- hazard = OR over live entries of (addr!=0 && (addr==rs || addr==rt)). Entries pushed in the current cycle are excluded; they appear next cycle.
- buf_count wraps never; overflow and underflow are impossible by the handshake rules. Assert this in verification.

Decomposition:
- Shared package cpu_pkg: REG_AW=5, DW, and the FSM state enum (ARB_IDLE, ARB_FORCE).
- One natural sub-module, rf_wbuf: the FIFO with per-entry live bits, the kill-by-address port, and the address-match vector used for hazard.
- The arbiter, age counter and FSM stay in the top.

Test Plan:
- MDU only: push {r5,0xA5A5A5A5} at cycle 0, wb_valid=0 → at cycle 1 RegWre=1, write=5, writeData=0xA5A5A5A5; buf_count back to 0.
- Priority: buffer holds {r3,1}; wb_valid=1 with {r4,2} for 2 cycles → r4 written both cycles, r3 written in cycle 3; hazard=1 for rs=3 until the pop.
- Full buffer: DEPTH pushes with WB busy → mdu_ready=0. With mdu_valid held and one pop, the push is accepted the cycle after buf_count drops.
- WAW kill: buffer {r7,0x11}; WB writes {r7,0x22} → later pop gives RegWre=0; r7 final value 0x22; hazard(rs=7)=0 after the kill.
- Starvation: buffer {r9,0x99}, wb_valid=1 continuously, STARVE_LIMIT=4 → FORCE on the 5th cycle. wb_stall=1 for one cycle, r9 written that cycle, WB request written the following cycle.
- Reset mid-drain: 2 entries buffered, RST low asynchronously → immediately buf_count=0, RegWre=0, hazard=0, wb_stall=0. After release, no stale write occurs.
